// File: rtl/fetch_queue_pkg.sv
// fetch_queue_pkg: shared pipeline constants used by the fetch and decode stages
package fetch_queue_pkg;
  localparam logic [31:0] PIPE_RESET_PC   = 32'hbfc00000;
  localparam logic [31:0] PIPE_RESET_INST = 32'h00000000;
endpackage

// File: rtl/fetch_queue.sv
// fetch_queue: registered FIFO of {pc, inst} between fetch and decode with flush
module fetch_queue
  import fetch_queue_pkg::*;
#(
  parameter int          DATA_W     = 32,
  parameter int          DEPTH      = 4,
  parameter logic [DATA_W-1:0] RESET_PC   = DATA_W'(PIPE_RESET_PC),
  parameter logic [DATA_W-1:0] RESET_INST = DATA_W'(PIPE_RESET_INST)
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic                     flush,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [DATA_W-1:0]        in_pc,
  input  logic [DATA_W-1:0]        in_inst,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [DATA_W-1:0]        out_pc,
  output logic [DATA_W-1:0]        out_inst,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [2*DATA_W-1:0] r_mem [DEPTH];
  logic [AW-1:0]       r_wptr;
  logic [AW-1:0]       r_rptr;
  logic [CW-1:0]       r_count;
  logic                w_push;
  logic                w_pop;

  assign in_ready  = r_count < CW'(DEPTH);
  assign out_valid = r_count != '0;
  assign w_push    = in_valid && in_ready && !flush;
  assign w_pop     = out_valid && out_ready && !flush;
  assign count     = r_count;
  // Head is shown straight from storage; the empty case falls back to the reset constants.
  assign out_pc    = out_valid ? r_mem[r_rptr][2*DATA_W-1:DATA_W] : RESET_PC;
  assign out_inst  = out_valid ? r_mem[r_rptr][DATA_W-1:0] : RESET_INST;

  // Storage needs no reset: entries are only visible when count covers them.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr] <= {in_pc, in_inst};
  end

  // Pointers wrap naturally at DEPTH (power of two); flush clears everything and wins.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else if (flush) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + AW'(1);
      if (w_pop) r_rptr <= r_rptr + AW'(1);
      if (w_push && !w_pop) r_count <= r_count + CW'(1);
      else if (w_pop && !w_push) r_count <= r_count - CW'(1);
    end
  end
endmodule

// File: tb/tb_fetch_queue.sv
// tb_fetch_queue: scoreboard-based self-checking bench for fetch_queue
module tb_fetch_queue;
  localparam logic [31:0] RPC   = 32'hbfc00000;
  localparam logic [31:0] RINST = 32'h00000000;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_pc = '0;
  logic [31:0] in_inst = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_pc;
  logic [31:0] out_inst;
  logic [2:0]  count;

  int n_checks = 0;
  int n_fail = 0;
  logic [63:0] sb[$];

  fetch_queue dut (
    .clk(clk), .resetn(resetn), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc), .in_inst(in_inst),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc), .out_inst(out_inst),
    .count(count)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] inst_of(input logic [31:0] pc);
    return pc ^ 32'h5a5a_1234;
  endfunction

  // Called just after a rising edge: drive, check outputs against the scoreboard, then update it.
  task automatic step(input logic v, input logic [31:0] pc, input logic rdy, input logic fl, input string tag);
    logic p, o;
    in_valid = v; in_pc = pc; in_inst = inst_of(pc); out_ready = rdy; flush = fl;
    @(negedge clk);
    check_eq({tag, ".count"}, 64'(count), 64'(sb.size()));
    check_eq({tag, ".in_ready"}, 64'(in_ready), 64'(sb.size() < 4));
    check_eq({tag, ".out_valid"}, 64'(out_valid), 64'(sb.size() != 0));
    check_eq({tag, ".out_pc"}, 64'(out_pc), sb.size() != 0 ? 64'(sb[0][63:32]) : 64'(RPC));
    check_eq({tag, ".out_inst"}, 64'(out_inst), sb.size() != 0 ? 64'(sb[0][31:0]) : 64'(RINST));
    p = v && sb.size() < 4 && !fl;
    o = rdy && sb.size() != 0 && !fl;
    @(posedge clk);
    if (fl) sb.delete();
    else begin
      if (o) void'(sb.pop_front());
      if (p) sb.push_back({pc, inst_of(pc)});
    end
    #1;
  endtask

  initial begin
    logic [31:0] pc;
    #12;
    check_eq("rst.count", 64'(count), 64'd0);
    check_eq("rst.in_ready", 64'(in_ready), 64'd1);
    check_eq("rst.out_valid", 64'(out_valid), 64'd0);
    check_eq("rst.out_pc", 64'(out_pc), 64'(RPC));
    check_eq("rst.out_inst", 64'(out_inst), 64'(RINST));
    @(negedge clk); resetn = 1'b1;
    @(posedge clk); #1;
    // idle inputs with in_valid low must not change state
    step(1'b0, 32'hdeadbeef, 1'b1, 1'b0, "idle");
    // fill to full, fifth offer refused
    for (int i = 0; i < 4; i++) step(1'b1, RPC + 32'(4 * i), 1'b0, 1'b0, "fill");
    step(1'b1, 32'h1111_2222, 1'b0, 1'b0, "fill5");
    check_eq("full.count", 64'(count), 64'd4);
    // drain in order, in_ready returns after first pop
    for (int i = 0; i < 4; i++) begin
      check_eq("drain.order", 64'(out_pc), 64'(RPC + 32'(4 * i)));
      step(1'b0, '0, 1'b1, 1'b0, "drain");
    end
    step(1'b0, '0, 1'b1, 1'b0, "empty");
    // concurrent push/pop at count 2 across pointer wrap
    pc = 32'h0000_1000;
    for (int i = 0; i < 2; i++) begin step(1'b1, pc, 1'b0, 1'b0, "pre2"); pc += 4; end
    for (int i = 0; i < 10; i++) begin
      step(1'b1, pc, 1'b1, 1'b0, "conc"); pc += 4;
      check_eq("conc.count2", 64'(count), 64'd2);
    end
    for (int i = 0; i < 2; i++) step(1'b0, '0, 1'b1, 1'b0, "conc_drain");
    // flush at count 3 with push and pop in the same cycle
    for (int i = 0; i < 3; i++) begin step(1'b1, pc, 1'b0, 1'b0, "pre3"); pc += 4; end
    step(1'b1, 32'h7777_0000, 1'b1, 1'b1, "flush");
    check_eq("flush.count", 64'(count), 64'd0);
    step(1'b0, '0, 1'b0, 1'b0, "postflush");
    step(1'b1, 32'h0000_2000, 1'b0, 1'b0, "afterflush_push");
    step(1'b0, '0, 1'b1, 1'b0, "afterflush_pop");
    // async reset mid-cycle at count 3
    for (int i = 0; i < 3; i++) begin step(1'b1, pc, 1'b0, 1'b0, "pre_rst"); pc += 4; end
    in_valid = 1'b0; out_ready = 1'b0;
    #2 resetn = 1'b0;
    #1;
    check_eq("arst.count", 64'(count), 64'd0);
    check_eq("arst.out_valid", 64'(out_valid), 64'd0);
    check_eq("arst.in_ready", 64'(in_ready), 64'd1);
    check_eq("arst.out_pc", 64'(out_pc), 64'(RPC));
    sb.delete();
    @(negedge clk); resetn = 1'b1;
    @(posedge clk); #1;
    step(1'b1, 32'hbfc00100, 1'b0, 1'b0, "arst_push");
    check_eq("arst.first_pc", 64'(out_pc), 64'h0000_0000_bfc0_0100);
    step(1'b0, '0, 1'b1, 1'b0, "arst_pop");
    step(1'b0, '0, 1'b0, 1'b0, "final");
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
